// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types and step arithmetic helpers for the synctimer subsystem.
// Step constants depend on per-instance NUMERATOR/DENOMINATOR, so helpers are functions.
package jellyvl_synctimer_pkg;

    localparam int unsigned DEFAULT_TIMER_WIDTH = 64;
    localparam int unsigned DEFAULT_NUMERATOR   = 10;
    localparam int unsigned DEFAULT_DENOMINATOR = 3;

    typedef logic [DEFAULT_TIMER_WIDTH-1:0] t_time;

    function automatic int unsigned calc_step_int(input int unsigned num, input int unsigned den);
        return num / den;
    endfunction

    function automatic int unsigned calc_step_frac(input int unsigned num, input int unsigned den);
        return num % den;
    endfunction

    function automatic int unsigned calc_frac_width(input int unsigned den);
        return (den < 2) ? 1 : $clog2(den + 1);
    endfunction

    localparam int unsigned STEP_INT  = calc_step_int(DEFAULT_NUMERATOR, DEFAULT_DENOMINATOR);
    localparam int unsigned STEP_FRAC = calc_step_frac(DEFAULT_NUMERATOR, DEFAULT_DENOMINATOR);

endpackage

// File: rtl/jellyvl_synctimer_timer_if.sv
// Set / adjust-token / local-time bundle between the adjuster side (master) and the timer (slave).
interface jellyvl_synctimer_timer_if #(
    parameter int unsigned TIMER_WIDTH = 64
);
    logic [TIMER_WIDTH-1:0] set_time;
    logic                   set_valid;
    logic                   adjust_sign;
    logic                   adjust_valid;
    logic                   adjust_ready;
    logic [TIMER_WIDTH-1:0] current_time;

    modport master (
        output set_time, set_valid, adjust_sign, adjust_valid,
        input  adjust_ready, current_time
    );

    modport slave (
        input  set_time, set_valid, adjust_sign, adjust_valid,
        output adjust_ready, current_time
    );
endinterface

// File: rtl/jellyvl_synctimer_step_gen.sv
// Fractional step accumulator: emits STEP_INT plus a carry every DENOMINATOR/STEP_FRAC clocks on average.
module jellyvl_synctimer_step_gen
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned NUMERATOR   = 10,
    parameter int unsigned DENOMINATOR = 3,
    parameter int unsigned INC_WIDTH   = 64
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 clear,
    output logic [INC_WIDTH-1:0] increment
);
    localparam int unsigned STEP_I = calc_step_int(NUMERATOR, DENOMINATOR);
    localparam int unsigned STEP_F = calc_step_frac(NUMERATOR, DENOMINATOR);
    localparam int unsigned FW     = calc_frac_width(DENOMINATOR);
    localparam int unsigned SW     = FW + 1;

    logic [FW-1:0] frac_q;
    logic [FW-1:0] frac_d;
    logic [SW-1:0] sum;
    logic          carry;

    always_comb begin
        sum       = {1'b0, frac_q} + SW'(STEP_F);
        carry     = (sum >= SW'(DENOMINATOR));
        frac_d    = carry ? FW'(sum - SW'(DENOMINATOR)) : FW'(sum);
        if (clear) begin
            frac_d = '0;
        end
        increment = INC_WIDTH'(STEP_I) + INC_WIDTH'(carry);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_d;
        end
    end
endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// Local time-of-day counter: fractional nominal step, +/-1 slew per accepted adjust token, absolute set.
module jellyvl_synctimer_timer
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned            TIMER_WIDTH = 64,
    parameter int unsigned            NUMERATOR   = 10,
    parameter int unsigned            DENOMINATOR = 3,
    parameter logic [TIMER_WIDTH-1:0] INIT_TIME   = '0
) (
    input logic                     reset,
    input logic                     clk,
    jellyvl_synctimer_timer_if.slave bus
);
    logic [TIMER_WIDTH-1:0] increment;
    logic [TIMER_WIDTH-1:0] adj;
    logic [TIMER_WIDTH-1:0] time_q;
    logic [TIMER_WIDTH-1:0] time_d;
    logic                   adjust_ready_q;
    logic                   adjust_ready_d;
    logic                   accept;

    jellyvl_synctimer_step_gen #(
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR),
        .INC_WIDTH   (TIMER_WIDTH)
    ) u_step_gen (
        .reset     (reset),
        .clk       (clk),
        .clear     (bus.set_valid),
        .increment (increment)
    );

    // A token accepted alongside a set is consumed (ready still drops) but has no effect on time.
    always_comb begin
        accept         = bus.adjust_valid && adjust_ready_q;
        adjust_ready_d = !accept;
        adj            = '0;
        if (accept) begin
            adj = bus.adjust_sign ? '1 : TIMER_WIDTH'(1);
        end
        if (bus.set_valid) begin
            time_d = bus.set_time;
        end else begin
            time_d = time_q + increment + adj;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q         <= INIT_TIME;
            adjust_ready_q <= 1'b0;
        end else begin
            time_q         <= time_d;
            adjust_ready_q <= adjust_ready_d;
        end
    end

    assign bus.adjust_ready = adjust_ready_q;
    assign bus.current_time = time_q;
endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Scoreboard bench: 64-bit and 8-bit timers share stimulus; expected time comes from k*N/D arithmetic.
module tb_jellyvl_synctimer_timer;
    localparam int unsigned NUM = 10;
    localparam int unsigned DEN = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jellyvl_synctimer_timer_if #(.TIMER_WIDTH(64)) b64 ();
    jellyvl_synctimer_timer_if #(.TIMER_WIDTH(8))  b8 ();

    jellyvl_synctimer_timer #(
        .TIMER_WIDTH (64), .NUMERATOR (NUM), .DENOMINATOR (DEN), .INIT_TIME ('0)
    ) dut64 (.reset (reset), .clk (clk), .bus (b64));

    jellyvl_synctimer_timer #(
        .TIMER_WIDTH (8), .NUMERATOR (NUM), .DENOMINATOR (DEN), .INIT_TIME ('0)
    ) dut8 (.reset (reset), .clk (clk), .bus (b8));

    longint unsigned exp_time_q[$];
    bit              exp_ready_q[$];
    int              errors = 0;
    int              checks = 0;

    // Reference: time = base + floor(k*NUM/DEN) + net adjust since last reset/set.
    longint unsigned m_base = 0;
    longint unsigned m_k    = 0;
    longint unsigned m_off  = 0;
    bit              m_ready = 1'b0;

    task automatic cyc(input bit rst, input bit sv, input longint unsigned st,
                       input bit av, input bit as);
        bit acc;
        reset            = rst;
        b64.set_valid    = sv;  b8.set_valid    = sv;
        b64.set_time     = st;  b8.set_time     = st[7:0];
        b64.adjust_valid = av;  b8.adjust_valid = av;
        b64.adjust_sign  = as;  b8.adjust_sign  = as;
        acc = av && m_ready && !rst;
        if (rst) begin
            m_base = 0; m_k = 0; m_off = 0; m_ready = 1'b0;
        end else if (sv) begin
            m_base = st; m_k = 0; m_off = 0; m_ready = !acc;
        end else begin
            m_k = m_k + 1;
            if (acc) m_off = as ? m_off - 1 : m_off + 1;
            m_ready = !acc;
        end
        exp_time_q.push_back(m_base + (m_k * NUM) / DEN + m_off);
        exp_ready_q.push_back(m_ready);
        @(negedge clk);
    endtask

    initial begin : monitor
        longint unsigned et;
        bit              er;
        logic [7:0]      et8;
        forever begin
            @(posedge clk);
            #1;
            if (exp_time_q.size() > 0) begin
                et  = exp_time_q.pop_front();
                er  = exp_ready_q.pop_front();
                et8 = et[7:0];
                checks++;
                if (b64.current_time !== et || b64.adjust_ready !== er) begin
                    errors++;
                    $display("FAIL w64 @%0t: time=%0d ready=%0b expected time=%0d ready=%0b",
                             $time, b64.current_time, b64.adjust_ready, et, er);
                end
                checks++;
                if (b8.current_time !== et8 || b8.adjust_ready !== er) begin
                    errors++;
                    $display("FAIL w8 @%0t: time=%0d ready=%0b expected time=%0d ready=%0b",
                             $time, b8.current_time, b8.adjust_ready, et8, er);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned wait_cnt;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        for (int unsigned i = 0; i < 30; i++) cyc(0, 0, 0, 0, 0);  // free run: 3,6,10,...,100
        for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);   // held + token: 2 accepts
        for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);                                        // single - token
        for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 0, 0, $urandom_range(0, 1) == 1);
        cyc(0, 1, 1000, 1, 0);                                     // set with same-cycle token
        for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 254, 0, 0);                                      // 8-bit wrap: 254 -> 1
        for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);                                        // reset mid-run with valid
        for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);                  // 64-bit wrap
        for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 31) == 0,
                {$urandom(), $urandom()},
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
        end
        cyc(0, 0, 0, 0, 0);
        wait_cnt = 0;
        while (exp_time_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_time_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected pending=0", exp_time_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
